// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS subset core (lw, sw, add, sub, and, or, slt, addi, beq, j)
// sharing one memory port for instruction fetch and data access.
//   state    | meaning
//   FETCH    | read instruction at PC, PC += 4
//   DECODE   | read rs/rt, precompute branch target, dispatch
//   MEMADR   | effective address for lw/sw
//   MEMRD    | data read from memory
//   MEMWB    | load result to rt
//   MEMWR    | data write to memory
//   RTEXEC   | R-type ALU operation
//   RTWB     | R-type result to rd
//   ADDIEXEC | A + signext(imm)
//   ADDIWB   | addi result to rt
//   BRANCH   | beq compare and PC update
//   JUMP     | j target to PC
//   TRAP     | halted until reset
module mips_multi_cycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          TRAP_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_debug,
  output logic [31:0] reg_v0,
  output logic        instr_retired,
  output logic        trap
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB,
    ADDIEXEC, ADDIWB, BRANCH, JUMP, TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  state_t      state, state_nxt;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_se, rs_val, rt_val, addr_calc, rt_result;
  logic        funct_ok;
  logic        req_s;
  logic [31:0] addr_s;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  assign opcode    = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign funct     = ir[5:0];
  assign imm_se    = {{16{ir[15]}}, ir[15:0]};
  assign rs_val    = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val    = (rt == 5'd0) ? 32'd0 : rf[rt];
  assign addr_calc = a + imm_se;

  always_comb begin
    rt_result = '0;
    funct_ok  = 1'b1;
    case (funct)
      6'h20:   rt_result = a + b;
      6'h22:   rt_result = a - b;
      6'h24:   rt_result = a & b;
      6'h25:   rt_result = a | b;
      6'h2a:   rt_result = {31'd0, $signed(a) < $signed(b)};
      default: funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_s         = 1'b0;
    mem_we        = 1'b0;
    addr_s        = pc;
    mem_wdata     = '0;
    instr_retired = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = rt;
    wr_data       = alu_out;
    case (state)
      FETCH: begin
        req_s = 1'b1;
        if (mem_ready) state_nxt = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = RTEXEC;
          OP_ADDI:      state_nxt = ADDIEXEC;
          OP_BEQ:       state_nxt = BRANCH;
          OP_J:         state_nxt = JUMP;
          default: begin
            if (TRAP_EN) state_nxt = TRAP;
            else begin
              instr_retired = 1'b1;
              state_nxt     = FETCH;
            end
          end
        endcase
      end
      MEMADR: begin
        if (TRAP_EN && addr_calc[1:0] != 2'b00) state_nxt = TRAP;
        else if (opcode == OP_LW)                 state_nxt = MEMRD;
        else                                      state_nxt = MEMWR;
      end
      MEMRD: begin
        req_s  = 1'b1;
        addr_s = alu_out;
        if (mem_ready) state_nxt = MEMWB;
      end
      MEMWB: begin
        wr_en         = 1'b1;
        wr_data       = mdr;
        instr_retired = 1'b1;
        state_nxt     = FETCH;
      end
      MEMWR: begin
        req_s     = 1'b1;
        mem_we    = 1'b1;
        addr_s    = alu_out;
        mem_wdata = b;
        if (mem_ready) begin
          instr_retired = 1'b1;
          state_nxt     = FETCH;
        end
      end
      RTEXEC: begin
        if (funct_ok)     state_nxt = RTWB;
        else if (TRAP_EN) state_nxt = TRAP;
        else begin
          instr_retired = 1'b1;
          state_nxt     = FETCH;
        end
      end
      RTWB: begin
        wr_en         = 1'b1;
        wr_addr       = rd;
        instr_retired = 1'b1;
        state_nxt     = FETCH;
      end
      ADDIEXEC: state_nxt = ADDIWB;
      ADDIWB: begin
        wr_en         = 1'b1;
        instr_retired = 1'b1;
        state_nxt     = FETCH;
      end
      BRANCH, JUMP: begin
        instr_retired = 1'b1;
        state_nxt     = FETCH;
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  // Reset gates the request directly so an in-flight access drops at once
  assign mem_req  = req_s & rst_n;
  assign mem_addr = {addr_s[31:2], 2'b00};
  assign pc_debug = pc;
  assign reg_v0   = rf[2];
  assign trap     = (state == TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        DECODE: begin
          a       <= rs_val;
          b       <= rt_val;
          alu_out <= pc + {imm_se[29:0], 2'b00};
        end
        MEMADR:   alu_out <= addr_calc;
        MEMRD:    if (mem_ready) mdr <= mem_rdata;
        RTEXEC:   alu_out <= rt_result;
        ADDIEXEC: alu_out <= addr_calc;
        BRANCH:   if (a == b) pc <= alu_out;
        JUMP:     pc <= {pc[31:28], ir[25:0], 2'b00};
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wr_en && wr_addr != 5'd0) begin
      rf[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mips_multi_cycle.sv
// Bench for mips_multi_cycle: two cores (TRAP_EN=1 at PC 0, TRAP_EN=0 at PC 0x100),
// each with a wait-state memory model; retirements and stores checked against queues.
module tb_mips_multi_cycle;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] v0;
    int          gap;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic [1:0]  rst_n;
  logic [1:0]  mem_req, mem_we, mem_ready, instr_retired, trap;
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] pc_debug [2];
  logic [31:0] reg_v0 [2];

  int          wait_n [2];
  logic [1:0]  ld_en;
  logic [31:0] ld_addr, ld_data;

  exp_t sbq [2][$];
  wr_t  wq  [2][$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   retires [2];
  int   last_ret [2];
  int   gap_seen [2];
  int   wcyc [2];
  logic [1:0] pend;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [256];
    int          cnt;

    mips_multi_cycle #(
      .RESET_PC (g == 0 ? 32'h0000_0000 : 32'h0000_0100),
      .TRAP_EN  (g == 0)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n[g]),
      .mem_req       (mem_req[g]),
      .mem_we        (mem_we[g]),
      .mem_addr      (mem_addr[g]),
      .mem_wdata     (mem_wdata[g]),
      .mem_rdata     (mem_rdata[g]),
      .mem_ready     (mem_ready[g]),
      .pc_debug      (pc_debug[g]),
      .reg_v0        (reg_v0[g]),
      .instr_retired (instr_retired[g]),
      .trap          (trap[g])
    );

    assign mem_ready[g] = mem_req[g] && (cnt == wait_n[g]);
    assign mem_rdata[g] = mem[mem_addr[g][9:2]];

    always @(posedge clk) begin
      if (ld_en[g]) mem[ld_addr[9:2]] <= ld_data;
      if (mem_req[g] && mem_ready[g]) begin
        cnt <= 0;
        if (mem_we[g]) mem[mem_addr[g][9:2]] <= mem_wdata[g];
      end else if (mem_req[g]) begin
        cnt <= cnt + 1;
      end else begin
        cnt <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int g, input logic [31:0] addr, input logic [31:0] data);
    ld_addr  = addr;
    ld_data  = data;
    ld_en[g] = 1'b1;
    @(posedge clk);
    #1 ld_en[g] = 1'b0;
  endtask

  task automatic push(input int g, input logic [31:0] pc, input logic [31:0] v0, input int gap);
    exp_t e;
    e.pc = pc; e.v0 = v0; e.gap = gap;
    sbq[g].push_back(e);
  endtask

  task automatic push_wr(input int g, input logic [31:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr; w.data = data;
    wq[g].push_back(w);
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_retires(input int g, input int n, input int budget);
    for (int i = 0; i < budget && retires[g] < n; i++) step();
    chk("wait_retires", retires[g], n);
  endtask

  // Retirement and store monitor; state after a retirement is checked one cycle later
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (pend[g]) begin
        pend[g] = 1'b0;
        chk("retire_expected", (sbq[g].size() != 0), 1'b1);
        if (sbq[g].size() != 0) begin
          exp_t e;
          e = sbq[g].pop_front();
          chk("retire_pc", pc_debug[g], e.pc);
          chk("retire_v0", reg_v0[g], e.v0);
          if (e.gap != 0) chk("retire_latency", gap_seen[g], e.gap);
        end
      end
      if (instr_retired[g]) begin
        pend[g]     = 1'b1;
        gap_seen[g] = cyc - last_ret[g];
        last_ret[g] = cyc;
        retires[g]++;
      end
      if (mem_req[g] && mem_we[g]) begin
        wcyc[g]++;
        chk("store_expected", (wq[g].size() != 0), 1'b1);
        if (wq[g].size() != 0) begin
          chk("store_addr", mem_addr[g], wq[g][0].addr);
          chk("store_data", mem_wdata[g], wq[g][0].data);
          if (mem_ready[g]) begin
            void'(wq[g].pop_front());
            chk("store_req_cycles", wcyc[g], wait_n[g] + 1);
            wcyc[g] = 0;
          end
        end
      end
    end
  end

  initial begin
    int req_hi;
    int base;
    rst_n = 2'b00;
    ld_en = 2'b00;
    pend  = 2'b00;
    wait_n = '{0, 0};
    retires = '{0, 0};
    last_ret = '{0, 0};
    wcyc = '{0, 0};
    ld_addr = '0;
    ld_data = '0;

    // Core 0 program: arithmetic, store/load with waits, $0 and slt, then jump into an illegal opcode
    load(0, 32'h00, 32'h2002_0005);  // addi $2,$0,5
    load(0, 32'h04, 32'h2003_0007);  // addi $3,$0,7
    load(0, 32'h08, 32'h0043_1020);  // add  $2,$2,$3
    load(0, 32'h0C, 32'hAC02_0008);  // sw   $2,8($0)
    load(0, 32'h10, 32'h8C04_0008);  // lw   $4,8($0)
    load(0, 32'h14, 32'h0084_1020);  // add  $2,$4,$4
    load(0, 32'h18, 32'h2000_0009);  // addi $0,$0,9
    load(0, 32'h1C, 32'h0000_1020);  // add  $2,$0,$0
    load(0, 32'h20, 32'h2005_FFFF);  // addi $5,$0,-1
    load(0, 32'h24, 32'h2006_0001);  // addi $6,$0,1
    load(0, 32'h28, 32'h00A6_102A);  // slt  $2,$5,$6
    load(0, 32'h2C, 32'h00C5_1022);  // sub  $2,$6,$5
    load(0, 32'h30, 32'h00A6_1024);  // and  $2,$5,$6
    load(0, 32'h34, 32'h0005_1025);  // or   $2,$0,$5
    load(0, 32'h38, 32'h00C5_102A);  // slt  $2,$6,$5
    load(0, 32'h3C, 32'h0800_0040);  // j    0x40
    load(0, 32'h100, 32'hFC00_0000); // illegal opcode

    step();
    chk("rst_mem_req0", mem_req[0], 1'b0);
    chk("rst_pc0", pc_debug[0], 32'h0);
    chk("rst_trap0", trap[0], 1'b0);
    chk("rst_retired0", instr_retired[0], 1'b0);
    chk("rst_v0_0", reg_v0[0], 32'h0);
    chk("rst_pc1", pc_debug[1], 32'h100);
    chk("rst_mem_req1", mem_req[1], 1'b0);

    push(0, 32'h04, 32'd5, 0);
    push(0, 32'h08, 32'd5, 4);
    push(0, 32'h0C, 32'd12, 4);
    push(0, 32'h10, 32'd12, 10);
    push(0, 32'h14, 32'd12, 11);
    push(0, 32'h18, 32'd24, 7);
    push(0, 32'h1C, 32'd24, 7);
    push(0, 32'h20, 32'd0, 7);
    push(0, 32'h24, 32'd0, 7);
    push(0, 32'h28, 32'd0, 7);
    push(0, 32'h2C, 32'd1, 7);
    push(0, 32'h30, 32'd2, 7);
    push(0, 32'h34, 32'd1, 7);
    push(0, 32'h38, 32'hFFFF_FFFF, 7);
    push(0, 32'h3C, 32'd0, 7);
    push(0, 32'h100, 32'd0, 6);
    push_wr(0, 32'h8, 32'd12);

    rst_n[0] = 1'b1;
    #1;
    chk("first_fetch_req", mem_req[0], 1'b1);
    chk("first_fetch_addr", mem_addr[0], 32'h0);
    for (int i = 0; i < 11; i++) step();
    chk("s1_v0_before_add", reg_v0[0], 32'd5);
    step();
    chk("s1_v0_after_12", reg_v0[0], 32'd12);
    chk("s1_retires", retires[0], 3);
    wait_n[0] = 3;

    for (int i = 0; i < 600 && !trap[0]; i++) step();
    chk("trap_set", trap[0], 1'b1);
    step();
    chk("trap_pc", pc_debug[0], 32'h104);
    chk("scoreboard_empty0", sbq[0].size(), 0);
    chk("stores_empty0", wq[0].size(), 0);
    req_hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_req[0]) req_hi++;
    end
    chk("trap_req_low", req_hi, 0);
    chk("trap_sticky", trap[0], 1'b1);
    chk("trap_no_retire", retires[0], 16);

    // Core 0 again: j to 0x10 then a beq loop on itself
    rst_n[0] = 1'b0;
    wait_n[0] = 0;
    load(0, 32'h00, 32'h0800_0004);  // j   0x4
    load(0, 32'h10, 32'h1000_FFFF);  // beq $0,$0,-1
    step();
    chk("rst_clears_trap", trap[0], 1'b0);
    base = retires[0];
    push(0, 32'h10, 32'd0, 0);
    for (int i = 0; i < 4; i++) push(0, 32'h10, 32'd0, 3);
    rst_n[0] = 1'b1;
    wait_retires(0, base + 5, 40);
    step();
    rst_n[0] = 1'b0;
    chk("scoreboard_empty_beq", sbq[0].size(), 0);

    // Core 1: illegal instructions as NOPs, misaligned store/load, reset mid-read
    wait_n[1] = 5;
    load(1, 32'h100, 32'hFC00_0000); // illegal opcode
    load(1, 32'h104, 32'h2002_0007); // addi $2,$0,7
    load(1, 32'h108, 32'hAC02_000A); // sw   $2,0xA($0)
    load(1, 32'h10C, 32'h8C02_000E); // lw   $2,0xE($0)
    load(1, 32'h110, 32'h0000_103F); // illegal funct
    load(1, 32'h114, 32'h8C02_0020); // lw   $2,0x20($0)
    load(1, 32'h0C, 32'h0000_1234);
    load(1, 32'h20, 32'h0000_DEAD);
    push(1, 32'h104, 32'd0, 0);
    push(1, 32'h108, 32'd7, 9);
    push(1, 32'h10C, 32'd7, 14);
    push(1, 32'h110, 32'h1234, 15);
    push(1, 32'h114, 32'h1234, 0);
    push_wr(1, 32'h8, 32'd7);
    step();
    rst_n[1] = 1'b1;
    #1;
    chk("first_fetch_addr1", mem_addr[1], 32'h100);

    for (int i = 0; i < 300 && !(mem_req[1] && !mem_we[1] && mem_addr[1] == 32'h20); i++) step();
    chk("lw_read_issued", mem_addr[1], 32'h20);
    step();
    step();
    chk("lw_waiting", mem_req[1] & ~mem_ready[1], 1'b1);
    #1 rst_n[1] = 1'b0;
    #1;
    chk("async_req_drop", mem_req[1], 1'b0);
    chk("reset_v0_cleared", reg_v0[1], 32'h0);
    chk("reset_pc", pc_debug[1], 32'h100);
    step();
    chk("reset_req_held_low", mem_req[1], 1'b0);
    chk("scoreboard_empty1", sbq[1].size(), 0);
    chk("stores_empty1", wq[1].size(), 0);
    chk("no_trap_en0", trap[1], 1'b0);

    push(1, 32'h104, 32'd0, 0);
    rst_n[1] = 1'b1;
    #1;
    chk("refetch_req", mem_req[1], 1'b1);
    chk("refetch_addr", mem_addr[1], 32'h100);
    chk("refetch_read", mem_we[1], 1'b0);
    base = retires[1];
    wait_retires(1, base + 1, 40);
    step();
    rst_n[1] = 1'b0;
    chk("scoreboard_final1", sbq[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
